timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Round-robin scheduler that shares one interval counter between `N_REQ` requesters. Each requester asks for a timed interval of `req_len` cycles; the scheduler arbitrates, grants the counter exclusively to one requester, runs the count, and returns a one-cycle `done` pulse tagged with the owner's id. It sits in front of the shared counter datapath and replaces per-client counters where intervals never need to overlap.

## Interface
- `N_REQ`, 4: number of requesters, at least 2.
- `WIDTH`, 8: counter and interval-length width.
- `ID_W`, `$clog2(N_REQ)`: requester-id width (derived; do not override).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N_REQ  per-requester request level.
- `req_len`  in  N_REQ*WIDTH  interval length; slice i = `[i*WIDTH +: WIDTH]`.
- `grant`  out  N_REQ  one-hot owner of the counter; all zero when not owned.
- `busy`  out  1  high whenever state ≠ IDLE.
- `count`  out  WIDTH  current counter value.
- `done`  out  1  one-cycle pulse when an interval completes.
- `done_id`  out  ID_W  owner id; valid while `done`=1, otherwise holds its last value.

## Operation
- Reset values: `grant`=0, `busy`=0, `count`=0, `done`=0, `done_id`=0, state=IDLE, round-robin pointer `last`=N_REQ-1, so requester 0 has first priority.
- States: IDLE, RUN, DONE. All outputs are registered.
- **IDLE:**
  - If any `req` is high, pick the first asserted index searching `last+1, last+2, …` with wrap-around.
  - Latch its `req_len` into `len_q` and set `last` to the winner.
  - Next cycle: `grant` = winner one-hot, `count`=0, state RUN.
  - If no `req` is high, stay in IDLE with all outputs unchanged.
- **RUN:**
  - `count` increments by 1 each cycle.
  - When `count == len_q`, go to DONE: next cycle `grant`=0, `done`=1, `done_id`=owner, and `count` holds.
  - Compare is at full `WIDTH`, so `len_q`=2^WIDTH-1 is legal and `count` never wraps.
- **DONE:** lasts one cycle, then IDLE unconditionally, with `done`=0 and `count`=0. `req` is not sampled in DONE.
- Requester handshake:
  - Hold `req` high and `req_len` stable from assertion until `done` with your id, or until you abort.
  - `req_len` is captured only at grant; later changes are ignored.
  - Drop `req` in the cycle `done` is observed. If `req` is still high in the following IDLE cycle, it is a new request, arbitrated normally; because `last` has advanced, other requesters win first.
- Abort: if the owner's `req` is low in any RUN cycle, the next cycle goes to IDLE with `grant`=0, `count`=0 and no `done` pulse. `last` keeps the aborted owner.
- Requests from non-owners during RUN or DONE wait; they are not queued beyond their level.
- `rst` asserted in any state forces the reset values on the next edge. An interval in flight is dropped with no `done`.

## Timing
- A request seen in IDLE at cycle 0 gives `grant` at cycle 1.
- `count` runs 0..len over cycles 1..1+len.
- `done` pulses at cycle 2+len; IDLE resumes at cycle 3+len.
- `len`=0 gives `grant` for exactly one cycle with `count`=0, then `done` at cycle 2.
- Back-to-back turnaround, from `done` to the next `grant`: 2 cycles (DONE, then IDLE arbitration).
- Worst-case wait for a continuously requesting client: (N_REQ-1) intervals plus their turnarounds.

## Structure
- Shared package `timer_sched_pkg`:
  - typedef enum `sched_state_t` {IDLE, RUN, DONE}.
  - Helper function `rr_pick(req, last)` returning the winner id.
- Sub-module `rr_arbiter`, parameterised on N_REQ:
  - Inputs: `req`, `last`. Outputs: `any`, `win_id`.
  - Combinational; the pointer register lives in the parent.
- Top level: FSM, `len_q`, counter and output registers.

## Test plan
- Single interval: `req[0]`=1 with len=3 at cycle 0 → `grant`=0001 for cycles 1–4, `count` 0,1,2,3, then `done`=1 with `done_id`=0 at cycle 5, `grant`=0.
- Simultaneous requests: after reset, `req`=0110 with len=2 each → requester 1 served first, `done` at cycle 4; requester 2 granted at cycle 6.
- Fairness: `req`=1111 held continuously with len=0, and each requester re-asserts after its `done` → grant order 0,1,2,3,0; no requester served twice before the others.
- Boundaries:
  - len=0 → one `grant` cycle, then `done`.
  - len=255 with WIDTH=8 → `count` reaches 255 without wrapping, `done` at cycle 257.
- Abort: owner drops `req` at count=2 of len=10 → `grant`=0 next cycle, no `done`, and the next pending requester is granted on the following cycle.
- Reset mid-run: `rst` pulsed at count=5 → all outputs zero the next cycle; after release, requester 0 wins over requester 3 when both are asserted.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and helpers for the timer scheduler.
//   sched_state_t : scheduler FSM state encoding
//   rr_pick       : round-robin winner search starting after 'last'
package timer_sched_pkg;

  // Largest requester count rr_pick can search; callers zero-extend req.
  localparam int MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Returns the first asserted index in last+1, last+2, ... (mod n_req).
  // If nothing is asserted the result is 'last' and must be ignored.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int last, input int n_req);
    int   idx;
    int   pick;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = last + k;
      if (idx >= n_req) idx = idx - n_req;
      if (!found && (k <= n_req) && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the 'last' pointer is held by the parent.
//   req    : request levels
//   last   : id of the most recent winner
//   any    : at least one request is asserted
//   win_id : winning id (valid when any=1)
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  always_comb begin
    any    = |req;
    win_id = ID_W'(rr_pick(MAX_REQ'(req), int'(last), N_REQ));
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one interval counter between N_REQ requesters, round-robin.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester request level
//   req_len  : packed interval lengths, slice i = [i*WIDTH +: WIDTH]
//   grant    : one-hot owner of the counter
//   busy     : scheduler not idle
//   count    : current counter value
//   done     : one-cycle completion pulse
//   done_id  : owner id of the completed interval (holds between pulses)
//
// state | meaning
// IDLE  | arbitrate pending requests, counter parked at 0
// RUN   | counting for the owner, compare against latched length
// DONE  | completion pulse cycle, no arbitration
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_len,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic                     done,
  output logic [ID_W-1:0]          done_id
);

  sched_state_t     state, state_d;
  logic [ID_W-1:0]  last, last_d;
  logic [ID_W-1:0]  owner, owner_d;
  logic [ID_W-1:0]  done_id_d;
  logic [ID_W-1:0]  win_id;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] count_d;
  logic [N_REQ-1:0] grant_d;
  logic             busy_d, done_d, any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .last   (last),
    .any    (any),
    .win_id (win_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= ID_W'(N_REQ - 1);
      owner   <= '0;
      len_q   <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state   <= state_d;
      last    <= last_d;
      owner   <= owner_d;
      len_q   <= len_d;
      grant   <= grant_d;
      busy    <= busy_d;
      count   <= count_d;
      done    <= done_d;
      done_id <= done_id_d;
    end
  end

  always_comb begin
    state_d   = state;
    last_d    = last;
    owner_d   = owner;
    len_d     = len_q;
    grant_d   = grant;
    count_d   = count;
    done_d    = 1'b0;
    done_id_d = done_id;
    case (state)
      IDLE: begin
        if (any) begin
          len_d   = req_len[win_id*WIDTH +: WIDTH];
          last_d  = win_id;
          owner_d = win_id;
          grant_d = N_REQ'(1) << win_id;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Owner withdrawal wins over completion on the final count.
        if (!req[owner]) begin
          grant_d = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (count == len_q) begin
          grant_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner;
          state_d   = DONE;
        end else begin
          count_d = count + WIDTH'(1);
        end
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_timer_scheduler.sv
module tb_timer_scheduler;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_len = '0;
  logic [N-1:0]   grant;
  logic           busy;
  logic [W-1:0]   count;
  logic           done;
  logic [IDW-1:0] done_id;

  timer_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: an interval is described by its grant cycle, length and owner;
  // every output is derived from the current cycle number against those.
  int   cyc        = 0;
  bit   mdl_ok     = 0;
  bit   m_run      = 0;
  int   m_g        = 0;
  int   m_len      = 0;
  int   m_owner    = 0;
  int   m_last     = N - 1;
  int   m_done_cyc = -1;
  int   m_done_id  = 0;
  int   m_idle_from = 0;

  always @(posedge clk) begin
    int t;
    int idx;
    bit found;
    t = cyc;
    if (rst) begin
      mdl_ok      = 1;
      m_run       = 0;
      m_len       = 0;
      m_last      = N - 1;
      m_done_cyc  = -1;
      m_done_id   = 0;
      m_idle_from = t + 1;
    end else if (m_run) begin
      if (!req[m_owner]) begin
        m_run       = 0;
        m_idle_from = t + 1;
      end else if (t == m_g + m_len) begin
        m_run       = 0;
        m_done_cyc  = t + 1;
        m_done_id   = m_owner;
        m_idle_from = t + 2;
      end
    end else if (t >= m_idle_from) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && req[idx]) begin
          found   = 1;
          m_run   = 1;
          m_g     = t + 1;
          m_owner = idx;
          m_last  = idx;
          m_len   = int'(req_len[idx*W +: W]);
        end
      end
    end
    cyc = t + 1;
  end

  function automatic int e_grant();
    return m_run ? (1 << m_owner) : 0;
  endfunction
  function automatic int e_done();
    return (cyc == m_done_cyc) ? 1 : 0;
  endfunction
  function automatic int e_count();
    if (m_run) return cyc - m_g;
    return (cyc == m_done_cyc) ? m_len : 0;
  endfunction
  function automatic int e_busy();
    return (m_run || (cyc == m_done_cyc)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("grant",   int'(grant),   e_grant());
      chk("busy",    int'(busy),    e_busy());
      chk("count",   int'(count),   e_count());
      chk("done",    int'(done),    e_done());
      chk("done_id", int'(done_id), m_done_id);
    end
  end

  // Literal expectation applied to both the DUT and the reference.
  task automatic lit(input string name, input int act, input int mdl, input int exp);
    chk(name, act, exp);
    chk({"model_", name}, mdl, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*W +: W] = W'(v);
  endtask

  int order[$];
  int fair_exp[5] = '{0, 1, 2, 3, 0};
  int lenv;

  initial begin
    do_reset();
    lit("rst_grant",   int'(grant),   e_grant(),  0);
    lit("rst_busy",    int'(busy),    e_busy(),   0);
    lit("rst_count",   int'(count),   e_count(),  0);
    lit("rst_done",    int'(done),    e_done(),   0);
    lit("rst_done_id", int'(done_id), m_done_id,  0);

    // single interval, len=3
    set_len(0, 3);
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      lit("single_grant", int'(grant), e_grant(), 1);
      lit("single_count", int'(count), e_count(), c - 1);
    end
    step();
    lit("single_done",    int'(done),    e_done(),  1);
    lit("single_done_id", int'(done_id), m_done_id, 0);
    lit("single_grant0",  int'(grant),   e_grant(), 0);
    req = '0;
    step();
    lit("single_idle", int'(busy), e_busy(), 0);

    // simultaneous requests 0110, len=2 each
    do_reset();
    set_len(1, 2);
    set_len(2, 2);
    req = 4'b0110;
    step();
    lit("sim_grant1", int'(grant), e_grant(), 2);
    repeat (3) step();
    lit("sim_done1", int'(done), e_done(), 1);
    lit("sim_id1",   int'(done_id), m_done_id, 1);
    req = 4'b0100;
    step();
    lit("sim_gap", int'(grant), e_grant(), 0);
    step();
    lit("sim_grant2", int'(grant), e_grant(), 4);
    repeat (3) step();
    lit("sim_done2", int'(done), e_done(), 1);
    lit("sim_id2",   int'(done_id), m_done_id, 2);
    req = '0;
    step();

    // fairness, len=0, all requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 0);
    req = 4'b1111;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      step();
      if (grant != '0) order.push_back($clog2(grant));
    end
    chk("fair_grants", order.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) chk("fair_order", order[k], fair_exp[k]);
    req = '0;
    step();
    step();

    // len=255 boundary
    do_reset();
    set_len(0, 255);
    req = 4'b0001;
    repeat (256) step();
    lit("max_count", int'(count), e_count(), 255);
    lit("max_grant", int'(grant), e_grant(), 1);
    step();
    lit("max_done",  int'(done),  e_done(),  1);
    lit("max_hold",  int'(count), e_count(), 255);
    req = '0;
    step();

    // abort at count=2 of len=10, requester 1 pending
    do_reset();
    set_len(0, 10);
    set_len(1, 1);
    req = 4'b0011;
    repeat (3) step();
    lit("abort_cnt2", int'(count), e_count(), 2);
    req[0] = 1'b0;
    step();
    lit("abort_grant", int'(grant), e_grant(), 0);
    lit("abort_done",  int'(done),  e_done(),  0);
    lit("abort_count", int'(count), e_count(), 0);
    step();
    lit("abort_next", int'(grant), e_grant(), 2);
    step();
    step();
    lit("abort_next_done", int'(done), e_done(), 1);
    req = '0;
    step();

    // reset mid-run, then 0 beats 3
    do_reset();
    set_len(0, 8);
    req = 4'b0001;
    repeat (6) step();
    lit("mid_cnt5", int'(count), e_count(), 5);
    rst = 1'b1;
    step();
    lit("mid_grant", int'(grant), e_grant(), 0);
    lit("mid_count", int'(count), e_count(), 0);
    lit("mid_busy",  int'(busy),  e_busy(),  0);
    rst = 1'b0;
    set_len(3, 4);
    req = 4'b1001;
    step();
    lit("mid_winner", int'(grant), e_grant(), 1);
    req = '0;

    // randomized traffic against the reference
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            lenv = ($urandom_range(0, 39) == 0) ? 255 : int'($urandom_range(0, 12));
            set_len(i, lenv);
            req[i] = 1'b1;
          end
        end else if (done && (done_id == IDW'(i))) begin
          if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
        end else if (grant[i]) begin
          if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 3) == 0) set_len(i, int'($urandom_range(0, 255)));
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
